pattern_blinker: RTL and testbench
==================================

# pattern_blinker

Parametrised multi-channel rate divider and LED/pin pattern generator, the successor to the fixed 20-bit divider and toggle pair driving the Fipsy LED. A shared programmable prescaler divides CLOCK (internal oscillator, nominally 2.08 MHz) into a tick. The tick steps a per-channel output engine: off, on, square wave, or an arbitrary serial bit pattern. The block sits between the OSCH instance and the top-level pins/LEDn.

## Interface
- WIDTH, 20: prescaler counter and DIVISOR width.
- CHANNELS, 4: number of independent outputs.
- PATTERN_BITS, 8: pattern length per channel; power of two, ≥2.
- CLOCK  in  1  sole clock; all state updates on its rising edge.
- RESET  in  1  synchronous, active-high reset.
- ENABLE  in  1  high: prescaler runs; low: everything freezes.
- DIVISOR  in  WIDTH  terminal count; tick period = DIVISOR+1 cycles.
- MODE  in  2*CHANNELS  channel c uses bits [2c+1:2c]: 00 off, 01 on, 10 square, 11 pattern.
- PATTERN  in  PATTERN_BITS*CHANNELS  channel c uses bits [PATTERN_BITS*c +: PATTERN_BITS]; bit 0 is emitted first.
- TICK  out  1  one-cycle pulse per prescaler wrap.
- PHASE  out  log2(PATTERN_BITS)  current pattern index, shared by all channels.
- OUT  out  CHANNELS  registered channel outputs, active-high. Top level inverts for LEDn.

## Operation
- Prescaler: count runs 0..div_shadow.
  - div_shadow is a copy of DIVISOR, loaded at reset and at every wrap.
  - Changing DIVISOR mid-period never shortens or corrupts the current period.
- Wrap condition: ENABLE && count == div_shadow. On the wrap edge:
  - count <= 0; div_shadow <= DIVISOR; TICK <= 1.
  - PHASE <= PHASE+1, wrapping from PATTERN_BITS-1 to 0.
  - toggle <= ~toggle.
- Otherwise, with ENABLE high: count <= count+1 and TICK <= 0.
- ENABLE low: count, div_shadow, PHASE and toggle hold; TICK <= 0. OUT continues to track MODE and PATTERN, but with no stepping.
- DIVISOR = 0: wrap every enabled cycle, so TICK stays high continuously.
- toggle is a single shared register. All square-mode channels are in phase regardless of when they entered square mode.
- OUT[c] is updated every edge:
  - off → 0
  - on → 1
  - square → toggle
  - pattern → PATTERN[c][PHASE]
- MODE, PATTERN and DIVISOR are synchronous inputs owned by the CLOCK domain. Asynchronous pins are synchronised by the instantiating level, not here.

## Timing
- Reset values (RESET sampled high): count 0; div_shadow = DIVISOR; TICK 0; PHASE 0; toggle 0; OUT all 0.
- RESET overrides ENABLE and wrap on the same edge. Reset mid-period restarts a full period from 0.
- Wrap edge at cycle n: TICK, PHASE and toggle change together, visible in cycle n+1. OUT reflects the new PHASE/toggle in cycle n+2 (one-cycle output register latency).
- MODE or PATTERN change: OUT reflects it one cycle later.
- Derived periods:
  - Square period = 2*(DIVISOR+1) cycles.
  - Pattern repeat = PATTERN_BITS*(DIVISOR+1) cycles.
- Example: 2 Hz square at 2.08 MHz uses DIVISOR = 519_999, which fits in WIDTH=20.
- No combinational paths from inputs to outputs.

## Structure
- Package pattern_blinker_pkg holds:
  - the mode constants MODE_OFF, MODE_ON, MODE_SQUARE, MODE_PATTERN (2-bit);
  - a helper function computing PHASE width from PATTERN_BITS.
- Sub-module rate_prescaler(WIDTH) contains count, div_shadow and TICK generation, with ports CLOCK, RESET, ENABLE, DIVISOR, TICK.
- The top of the block holds PHASE, toggle, the per-channel mux and the OUT register, using a generate loop over CHANNELS.

## Test plan
- Period: DIVISOR=3, ENABLE=1, release RESET → TICK high exactly one cycle in every 4. First TICK is 4 cycles after reset release; PHASE increments 0→1→…→7→0.
- Modes: CHANNELS=4, MODE=11_10_01_00, PATTERN ch3=8'b1011_0001, DIVISOR=1 → OUT[0]=0; OUT[1]=1; OUT[2] toggles every 2 cycles; OUT[3] emits 1,0,0,0,1,1,0,1, each bit held 2 cycles, repeating.
- Divisor shadowing: DIVISOR=9; change it to 2 at count=4 → current period still completes at 10 cycles, then 3-cycle periods follow.
- ENABLE freeze: deassert ENABLE for 5 cycles mid-period with DIVISOR=7 → no TICK, PHASE/toggle unchanged. The period resumes and completes 5 cycles late; OUT follows a MODE change during the freeze after 1 cycle.
- Reset mid-operation: RESET pulse while count=5 and PHASE=3 → next cycle all outputs 0, PHASE 0. First TICK arrives DIVISOR+1 cycles after release; RESET overrides a coincident wrap.
- DIVISOR=0 → TICK continuously high; square-mode output toggles every cycle; PHASE counts every cycle.

Source files
------------

// File: rtl/pattern_blinker_pkg.sv
// Shared definitions for the pattern_blinker block: channel mode encoding
// and the PHASE width helper.
package pattern_blinker_pkg;

  typedef enum logic [1:0] {
    MODE_OFF     = 2'b00,
    MODE_ON      = 2'b01,
    MODE_SQUARE  = 2'b10,
    MODE_PATTERN = 2'b11
  } mode_e;

  function automatic int phase_width(input int pattern_bits);
    return (pattern_bits > 1) ? $clog2(pattern_bits) : 1;
  endfunction

endpackage

// File: rtl/pattern_blinker_if.sv
// Control and status bundle between a pattern_blinker and whatever programs it.
interface pattern_blinker_if
  import pattern_blinker_pkg::*;
#(
  parameter int WIDTH        = 20,
  parameter int CHANNELS     = 4,
  parameter int PATTERN_BITS = 8
);

  localparam int PHASE_W = phase_width(PATTERN_BITS);

  logic                             ENABLE;
  logic [WIDTH-1:0]                 DIVISOR;
  logic [2*CHANNELS-1:0]            MODE;
  logic [PATTERN_BITS*CHANNELS-1:0] PATTERN;
  logic                             TICK;
  logic [PHASE_W-1:0]               PHASE;
  logic [CHANNELS-1:0]              OUT;

  modport master (
    output ENABLE, DIVISOR, MODE, PATTERN,
    input  TICK, PHASE, OUT
  );

  modport slave (
    input  ENABLE, DIVISOR, MODE, PATTERN,
    output TICK, PHASE, OUT
  );

endinterface

// File: rtl/pattern_blinker_rate_prescaler.sv
// Programmable prescaler: counts 0..div_shadow and emits a one-cycle TICK per wrap.
// DIVISOR is only sampled at reset and at each wrap, so a period is never cut short.
module rate_prescaler #(
  parameter int WIDTH = 20
) (
  input  logic             CLOCK,
  input  logic             RESET,
  input  logic             ENABLE,
  input  logic [WIDTH-1:0] DIVISOR,
  output logic             TICK
);

  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] div_shadow_q, div_shadow_d;
  logic             tick_q, tick_d;
  logic             wrap;

  // NOTE: every signal written here gets a default before any branch, so no latch is inferred.
  always_comb begin
    wrap         = ENABLE && (count_q == div_shadow_q);
    count_d      = count_q;
    div_shadow_d = div_shadow_q;
    tick_d       = 1'b0;
    if (wrap) begin
      count_d      = '0;
      div_shadow_d = DIVISOR;
      tick_d       = 1'b1;
    end else if (ENABLE) begin
      count_d = count_q + WIDTH'(1);
    end
  end

  // NOTE: state uses non-blocking '<=' so every flop updates from pre-edge values.
  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      count_q      <= '0;
      div_shadow_q <= DIVISOR;
      tick_q       <= 1'b0;
    end else begin
      count_q      <= count_d;
      div_shadow_q <= div_shadow_d;
      tick_q       <= tick_d;
    end
  end

  assign TICK = tick_q;

endmodule

// File: rtl/pattern_blinker.sv
// Multi-channel LED/pin pattern generator: shared prescaler, shared PHASE and
// square-wave toggle, and a registered per-channel output mux.
module pattern_blinker
  import pattern_blinker_pkg::*;
#(
  parameter int WIDTH        = 20,
  parameter int CHANNELS     = 4,
  parameter int PATTERN_BITS = 8
) (
  input  logic              CLOCK,
  input  logic              RESET,
  pattern_blinker_if.slave  bus
);

  localparam int PHASE_W = phase_width(PATTERN_BITS);

  logic                tick;
  logic [PHASE_W-1:0]  phase_base_q, phase_base_d, phase;
  logic                toggle_base_q, toggle_base_d, toggle;
  logic [CHANNELS-1:0] out_q, out_d;

  rate_prescaler #(.WIDTH(WIDTH)) u_prescaler (
    .CLOCK   (CLOCK),
    .RESET   (RESET),
    .ENABLE  (bus.ENABLE),
    .DIVISOR (bus.DIVISOR),
    .TICK    (tick)
  );

  // TICK is the registered wrap flag; folding it into the base registers makes
  // PHASE and toggle step on the same edge as TICK, while the bases absorb it next cycle.
  assign phase  = phase_base_q + PHASE_W'(tick);
  assign toggle = toggle_base_q ^ tick;

  always_comb begin
    phase_base_d  = phase;
    toggle_base_d = toggle;
  end

  for (genvar c = 0; c < CHANNELS; c++) begin : g_chan
    logic [PATTERN_BITS-1:0] pat;
    logic                    out_nxt;

    assign pat = bus.PATTERN[PATTERN_BITS*c +: PATTERN_BITS];

    always_comb begin
      out_nxt = 1'b0;
      case (mode_e'(bus.MODE[2*c +: 2]))
        MODE_OFF:     out_nxt = 1'b0;
        MODE_ON:      out_nxt = 1'b1;
        MODE_SQUARE:  out_nxt = toggle;
        MODE_PATTERN: out_nxt = pat[phase];
        default:      out_nxt = 1'b0;
      endcase
    end

    assign out_d[c] = out_nxt;
  end

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      phase_base_q  <= '0;
      toggle_base_q <= 1'b0;
      out_q         <= '0;
    end else begin
      phase_base_q  <= phase_base_d;
      toggle_base_q <= toggle_base_d;
      out_q         <= out_d;
    end
  end

  assign bus.TICK  = tick;
  assign bus.PHASE = phase;
  assign bus.OUT   = out_q;

endmodule

// File: tb/tb_pattern_blinker.sv
// Scoreboard bench for pattern_blinker: a period-level reference model pushes the
// expected outputs each edge, a monitor pops and compares them on the falling edge.
module tb_pattern_blinker;
  import pattern_blinker_pkg::*;

  localparam int WIDTH        = 20;
  localparam int CHANNELS     = 4;
  localparam int PATTERN_BITS = 8;
  localparam int PHASE_W      = $clog2(PATTERN_BITS);

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pattern_blinker_if #(.WIDTH(WIDTH), .CHANNELS(CHANNELS), .PATTERN_BITS(PATTERN_BITS)) bus ();

  pattern_blinker #(.WIDTH(WIDTH), .CHANNELS(CHANNELS), .PATTERN_BITS(PATTERN_BITS)) dut (
    .CLOCK (clk),
    .RESET (rst),
    .bus   (bus)
  );

  typedef struct {
    logic                tick;
    logic [PHASE_W-1:0]  phase;
    logic [CHANNELS-1:0] out;
  } exp_t;

  exp_t exp_q[$];
  int   tests_run    = 0;
  int   tests_failed = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests_run++;
    if (act !== req) begin
      tests_failed++;
      $display("FAIL %s: got %0h, required %0h at t=%0t", name, act, req, $time);
    end
  endtask

  // Reference model: a period is DIVISOR+1 enabled cycles, DIVISOR latched at the
  // start of each period; PHASE and toggle are just the number of completed periods.
  int unsigned         m_elapsed;
  int unsigned         m_period;
  int unsigned         m_ticks;
  logic                m_tick;
  logic [CHANNELS-1:0] m_out;

  always @(posedge clk) begin
    exp_t        e;
    int unsigned cur_phase;
    int unsigned cur_toggle;
    cur_phase  = m_ticks % PATTERN_BITS;
    cur_toggle = m_ticks % 2;
    for (int c = 0; c < CHANNELS; c++) begin
      case (bus.MODE[2*c +: 2])
        2'b00:   m_out[c] = 1'b0;
        2'b01:   m_out[c] = 1'b1;
        2'b10:   m_out[c] = (cur_toggle == 1);
        default: m_out[c] = bus.PATTERN[PATTERN_BITS*c + cur_phase];
      endcase
    end
    if (rst) begin
      m_elapsed = 0;
      m_period  = int'(bus.DIVISOR) + 1;
      m_ticks   = 0;
      m_tick    = 1'b0;
      m_out     = '0;
    end else if (bus.ENABLE) begin
      m_elapsed++;
      if (m_elapsed == m_period) begin
        m_tick    = 1'b1;
        m_ticks++;
        m_elapsed = 0;
        m_period  = int'(bus.DIVISOR) + 1;
      end else begin
        m_tick = 1'b0;
      end
    end else begin
      m_tick = 1'b0;
    end
    e.tick  = m_tick;
    e.phase = PHASE_W'(m_ticks % PATTERN_BITS);
    e.out   = m_out;
    exp_q.push_back(e);
  end

  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("tick",  32'(bus.TICK),  32'(e.tick));
      check("phase", 32'(bus.PHASE), 32'(e.phase));
      check("out",   32'(bus.OUT),   32'(e.out));
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    step(1);
    rst = 1'b0;
  endtask

  task automatic wait_tick(input int budget);
    bit seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      step(1);
      if (bus.TICK === 1'b1) seen = 1'b1;
    end
    check("tick_wait", 32'(seen), 32'd1);
  endtask

  initial begin
    bus.ENABLE  = 1'b1;
    bus.DIVISOR = WIDTH'(3);
    bus.MODE    = 8'b11_10_01_00;
    bus.PATTERN = {8'hB1, 24'h5A_C3_0F};
    step(2);
    rst = 1'b0;

    // Period: DIVISOR=3, PHASE walks a full cycle and wraps.
    step(40);

    // Modes with DIVISOR=1 and ch3 pattern 1011_0001.
    bus.DIVISOR = WIDTH'(1);
    pulse_reset();
    step(40);

    // Divisor shadowing: change 9 -> 2 mid-period.
    bus.DIVISOR = WIDTH'(9);
    pulse_reset();
    step(4);
    bus.DIVISOR = WIDTH'(2);
    step(30);

    // ENABLE freeze with a MODE change during the freeze.
    bus.DIVISOR = WIDTH'(7);
    pulse_reset();
    step(4);
    bus.ENABLE = 1'b0;
    step(2);
    bus.MODE = 8'b10_11_00_01;
    step(3);
    bus.ENABLE = 1'b1;
    step(30);

    // Reset mid-operation at PHASE=3, count=5.
    bus.MODE = 8'b11_10_01_00;
    pulse_reset();
    step(3 * 8 + 5);
    pulse_reset();
    step(20);

    // Reset on the same edge as a wrap.
    bus.DIVISOR = WIDTH'(3);
    pulse_reset();
    wait_tick(20);
    step(3);
    pulse_reset();
    step(12);

    // DIVISOR=0: TICK stays high, PHASE and toggle step every cycle.
    bus.DIVISOR = WIDTH'(0);
    pulse_reset();
    step(20);

    // Randomised traffic.
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 7) == 0)  bus.DIVISOR = WIDTH'($urandom_range(0, 6));
      bus.ENABLE = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 9) == 0)  bus.MODE = 8'($urandom);
      if ($urandom_range(0, 19) == 0) bus.PATTERN = $urandom;
      rst = ($urandom_range(0, 99) == 0);
      step(1);
    end
    rst = 1'b0;
    step(2);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
